// File: rtl/router_ctrl_pkg.sv
// router_pkg: shared FSM state type, port count and header field positions
// for the router control slice.
package router_pkg;

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      LOAD_PARITY,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      WAIT_TILL_EMPTY,
      CHECK_PARITY_ERROR
   } state_t;

   localparam int         NUM_PORTS    = 3;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 1;
   localparam int LEN_LSB  = 2;
   localparam int LEN_MSB  = 7;

   // Per-port flag lookup that reads as 0 for the unused address 3.
   function automatic logic port_bit(input logic [NUM_PORTS-1:0] v, input logic [1:0] a);
      return (a == ADDR_INVALID) ? 1'b0 : v[a];
   endfunction

endpackage

// File: rtl/router_ctrl_if.sv
// router_ctrl_if: all non-clock signals between the router controller and its
// neighbours; master is the controller's view, slave the surrounding blocks'.
interface router_ctrl_if;
   import router_pkg::*;

   logic                 pkt_valid;
   logic [7:0]           data_in;
   logic [NUM_PORTS-1:0] fifo_full;
   logic [NUM_PORTS-1:0] fifo_empty;
   logic [NUM_PORTS-1:0] read_enb;
   logic                 parity_done;
   logic                 low_pkt_valid;

   logic [NUM_PORTS-1:0] write_enb;
   logic [NUM_PORTS-1:0] soft_reset;
   logic [NUM_PORTS-1:0] vld_out;
   logic                 detect_add;
   logic                 lfd_state;
   logic                 ld_state;
   logic                 laf_state;
   logic                 full_state;
   logic                 rst_int_reg;
   logic                 fifo_full_sel;
   logic                 busy;

   modport master (
      input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
      output write_enb, soft_reset, vld_out, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, fifo_full_sel, busy
   );

   modport slave (
      output pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
      input  write_enb, soft_reset, vld_out, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, fifo_full_sel, busy
   );

endinterface

// File: rtl/router_ctrl_timeout.sv
// router_timeout: counts consecutive cycles a destination leaves valid data
// unread and emits a one-cycle registered soft_reset at the terminal count.
module router_timeout #(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic clock,
   input  logic resetn,
   input  logic vld_out,
   input  logic read_enb,
   output logic soft_reset
);
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   // A read in the terminal cycle clears the count before the pulse can fire.
   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      pulse_d = 1'b0;
      if (read_enb || !vld_out) begin
         cnt_d = '0;
      end else if (cnt_q == TERM_CNT) begin
         cnt_d   = '0;
         pulse_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign soft_reset = pulse_q;

endmodule

// File: rtl/router_ctrl.sv
// router_ctrl: packet sequencing FSM for the 1x3 router. Define
// ROUTER_CTRL_TIMEOUT_EN to build the per-port stall timeouts (soft_reset).
module router_ctrl
   import router_pkg::*;
#(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic          clock,
   input  logic          resetn,
   router_ctrl_if.master bus
);
   state_t               state_q, state_d;
   logic [1:0]           addr_q, addr_d;
   logic [1:0]           hdr_addr;
   logic                 write_asserted;
   logic                 fifo_full_sel;
   logic                 detect_add, lfd_state, ld_state, laf_state;
   logic                 full_state, rst_int_reg, busy;
   logic [NUM_PORTS-1:0] vld_out;
   logic [NUM_PORTS-1:0] soft_reset;

   assign hdr_addr      = bus.data_in[ADDR_MSB:ADDR_LSB];
   assign fifo_full_sel = port_bit(bus.fifo_full, addr_q);
   assign vld_out       = ~bus.fifo_empty;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      write_asserted = 1'b0;
      detect_add     = 1'b0;
      lfd_state      = 1'b0;
      ld_state       = 1'b0;
      laf_state      = 1'b0;
      full_state     = 1'b0;
      rst_int_reg    = 1'b0;
      busy           = 1'b0;
      unique case (state_q)
         DECODE_ADDRESS: begin
            detect_add = 1'b1;
            if (bus.pkt_valid) begin
               addr_d = hdr_addr;
               if (hdr_addr != ADDR_INVALID)
                  state_d = port_bit(bus.fifo_empty, hdr_addr) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
         end
         WAIT_TILL_EMPTY: begin
            busy = 1'b1;
            if (port_bit(bus.fifo_empty, addr_q)) state_d = LOAD_FIRST_DATA;
         end
         LOAD_FIRST_DATA: begin
            lfd_state      = 1'b1;
            busy           = 1'b1;
            write_asserted = 1'b1;
            state_d        = LOAD_DATA;
         end
         LOAD_DATA: begin
            ld_state       = 1'b1;
            write_asserted = ~fifo_full_sel;
            // Full outranks the end of the packet.
            if (fifo_full_sel)      state_d = FIFO_FULL_STATE;
            else if (!bus.pkt_valid) state_d = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            full_state = 1'b1;
            busy       = 1'b1;
            if (!fifo_full_sel) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            laf_state      = 1'b1;
            busy           = 1'b1;
            write_asserted = 1'b1;
            if (bus.parity_done)        state_d = DECODE_ADDRESS;
            else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
            else                        state_d = LOAD_DATA;
         end
         LOAD_PARITY: begin
            busy           = 1'b1;
            write_asserted = 1'b1;
            state_d        = CHECK_PARITY_ERROR;
         end
         CHECK_PARITY_ERROR: begin
            rst_int_reg = 1'b1;
            busy        = 1'b1;
            state_d     = fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
      endcase
   end

`ifdef ROUTER_CTRL_TIMEOUT_EN
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_timeout
      router_timeout #(
         .TIMEOUT (TIMEOUT),
         .CNT_W   (CNT_W)
      ) u_timeout (
         .clock      (clock),
         .resetn     (resetn),
         .vld_out    (vld_out[gi]),
         .read_enb   (bus.read_enb[gi]),
         .soft_reset (soft_reset[gi])
      );
   end
`else
   assign soft_reset = '0;
`endif

   assign bus.write_enb     = write_asserted ? (NUM_PORTS'(1) << addr_q) : '0;
   assign bus.soft_reset    = soft_reset;
   assign bus.vld_out       = vld_out;
   assign bus.fifo_full_sel = fifo_full_sel;
   assign bus.detect_add    = detect_add;
   assign bus.lfd_state     = lfd_state;
   assign bus.ld_state      = ld_state;
   assign bus.laf_state     = laf_state;
   assign bus.full_state    = full_state;
   assign bus.rst_int_reg   = rst_int_reg;
   assign bus.busy          = busy;

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed and randomized checks of the router controller
// against packet-level expectations and a stall-streak timeout model.
module tb_router_ctrl;
   import router_pkg::*;

   localparam int TIMEOUT = 30;
`ifdef ROUTER_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // Decode vector: {detect_add, lfd, ld, laf, full, rst_int_reg, busy}
   localparam logic [6:0] D_DA   = 7'b1000000;
   localparam logic [6:0] D_LFD  = 7'b0100001;
   localparam logic [6:0] D_LD   = 7'b0010000;
   localparam logic [6:0] D_LAF  = 7'b0001001;
   localparam logic [6:0] D_FULL = 7'b0000101;
   localparam logic [6:0] D_LP   = 7'b0000001;
   localparam logic [6:0] D_CPE  = 7'b0000011;
   localparam logic [6:0] D_WTE  = 7'b0000001;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp  = 0;
   int   n_err  = 0;
   logic [6:0] dec;

   router_ctrl_if bus();

   router_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   assign dec = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                 bus.full_state, bus.rst_int_reg, bus.busy};

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pkt_valid     = 1'b0;
      bus.data_in       = 8'h00;
      bus.fifo_full     = 3'b000;
      bus.fifo_empty    = 3'b111;
      bus.read_enb      = 3'b000;
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      tick();
      tick();
      #1;
      n_cmp++; if (dec !== D_DA) begin n_err++; $display("FAIL reset_dec: got %b want %b", dec, D_DA); end
      n_cmp++; if (bus.write_enb !== 3'b000) begin n_err++; $display("FAIL reset_we: got %b want 000", bus.write_enb); end
      n_cmp++; if (bus.soft_reset !== 3'b000) begin n_err++; $display("FAIL reset_srst: got %b want 000", bus.soft_reset); end
      n_cmp++; if (bus.vld_out !== 3'b000) begin n_err++; $display("FAIL reset_vld: got %b want 000", bus.vld_out); end
      resetn = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_packet();
      int writes = 0;
      bus.pkt_valid = 1'b1;
      bus.data_in   = 8'h0D;
      #1;
      n_cmp++; if (dec !== D_DA) begin n_err++; $display("FAIL pkt_da: got %b want %b", dec, D_DA); end
      if (bus.write_enb !== 3'b000) writes++;
      tick();
      #1;
      n_cmp++; if (dec !== D_LFD) begin n_err++; $display("FAIL pkt_lfd: got %b want %b", dec, D_LFD); end
      n_cmp++; if (bus.write_enb !== 3'b010) begin n_err++; $display("FAIL pkt_lfd_we: got %b want 010", bus.write_enb); end
      if (bus.write_enb !== 3'b000) writes++;
      for (int k = 0; k < 3; k++) begin
         tick();
         bus.pkt_valid = (k < 2);
         bus.data_in   = 8'($urandom);
         #1;
         n_cmp++; if (dec !== D_LD) begin n_err++; $display("FAIL pkt_ld%0d: got %b want %b", k, dec, D_LD); end
         n_cmp++; if (bus.write_enb !== 3'b010) begin n_err++; $display("FAIL pkt_ld%0d_we: got %b want 010", k, bus.write_enb); end
         if (bus.write_enb !== 3'b000) writes++;
      end
      tick();
      #1;
      n_cmp++; if (dec !== D_LP) begin n_err++; $display("FAIL pkt_lp: got %b want %b", dec, D_LP); end
      if (bus.write_enb !== 3'b000) writes++;
      tick();
      #1;
      n_cmp++; if (dec !== D_CPE) begin n_err++; $display("FAIL pkt_cpe: got %b want %b", dec, D_CPE); end
      if (bus.write_enb !== 3'b000) writes++;
      tick();
      #1;
      n_cmp++; if (dec !== D_DA) begin n_err++; $display("FAIL pkt_back_da: got %b want %b", dec, D_DA); end
      n_cmp++; if (writes != 5) begin n_err++; $display("FAIL pkt_writes: got %0d want 5", writes); end
      $display("test_packet addr 1 writes %0d", writes);
   endtask

   task automatic test_bad_addr();
      bus.pkt_valid = 1'b1;
      bus.data_in   = 8'h13;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++; if (dec !== D_DA) begin n_err++; $display("FAIL badaddr_dec%0d: got %b want %b", k, dec, D_DA); end
         n_cmp++; if (bus.write_enb !== 3'b000) begin n_err++; $display("FAIL badaddr_we%0d: got %b want 000", k, bus.write_enb); end
         tick();
      end
      bus.pkt_valid = 1'b0;
      $display("test_bad_addr done");
   endtask

   task automatic test_wait_empty();
      bus.fifo_empty = 3'b011;
      bus.pkt_valid  = 1'b1;
      bus.data_in    = 8'h0A;
      tick();
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (dec !== D_WTE) begin n_err++; $display("FAIL wte_dec%0d: got %b want %b", k, dec, D_WTE); end
         n_cmp++; if (bus.write_enb !== 3'b000) begin n_err++; $display("FAIL wte_we%0d: got %b want 000", k, bus.write_enb); end
         n_cmp++; if (bus.vld_out !== 3'b100) begin n_err++; $display("FAIL wte_vld%0d: got %b want 100", k, bus.vld_out); end
         tick();
      end
      bus.fifo_empty = 3'b111;
      tick();
      #1;
      n_cmp++; if (dec !== D_LFD) begin n_err++; $display("FAIL wte_lfd: got %b want %b", dec, D_LFD); end
      n_cmp++; if (bus.write_enb !== 3'b100) begin n_err++; $display("FAIL wte_lfd_we: got %b want 100", bus.write_enb); end
      tick();
      bus.pkt_valid = 1'b0;
      tick();
      tick();
      tick();
      #1;
      n_cmp++; if (dec !== D_DA) begin n_err++; $display("FAIL wte_back_da: got %b want %b", dec, D_DA); end
      $display("test_wait_empty addr 2 done");
   endtask

   task automatic test_full();
      bus.pkt_valid = 1'b1;
      bus.data_in   = 8'h10;
      tick();
      tick();
      #1;
      n_cmp++; if (bus.write_enb !== 3'b001) begin n_err++; $display("FAIL full_ld_we: got %b want 001", bus.write_enb); end
      tick();
      bus.fifo_full = 3'b001;
      #1;
      n_cmp++; if (bus.write_enb !== 3'b000) begin n_err++; $display("FAIL full_ld_blocked: got %b want 000", bus.write_enb); end
      n_cmp++; if (bus.fifo_full_sel !== 1'b1) begin n_err++; $display("FAIL full_sel: got %b want 1", bus.fifo_full_sel); end
      tick();
      tick();
      #1;
      n_cmp++; if (dec !== D_FULL) begin n_err++; $display("FAIL full_dec: got %b want %b", dec, D_FULL); end
      n_cmp++; if (bus.write_enb !== 3'b000) begin n_err++; $display("FAIL full_we: got %b want 000", bus.write_enb); end
      bus.fifo_full = 3'b000;
      tick();
      #1;
      n_cmp++; if (dec !== D_LAF) begin n_err++; $display("FAIL laf_dec: got %b want %b", dec, D_LAF); end
      n_cmp++; if (bus.write_enb !== 3'b001) begin n_err++; $display("FAIL laf_we: got %b want 001", bus.write_enb); end
      tick();
      // Full and end-of-packet together: full must win.
      bus.fifo_full = 3'b001;
      bus.pkt_valid = 1'b0;
      #1;
      n_cmp++; if (dec !== D_LD) begin n_err++; $display("FAIL laf_to_ld: got %b want %b", dec, D_LD); end
      tick();
      #1;
      n_cmp++; if (dec !== D_FULL) begin n_err++; $display("FAIL full_priority: got %b want %b", dec, D_FULL); end
      bus.fifo_full     = 3'b000;
      bus.low_pkt_valid = 1'b1;
      tick();
      #1;
      n_cmp++; if (dec !== D_LAF) begin n_err++; $display("FAIL laf2_dec: got %b want %b", dec, D_LAF); end
      tick();
      bus.low_pkt_valid = 1'b0;
      #1;
      n_cmp++; if (dec !== D_LP) begin n_err++; $display("FAIL laf_to_lp: got %b want %b", dec, D_LP); end
      tick();
      tick();
      #1;
      n_cmp++; if (dec !== D_DA) begin n_err++; $display("FAIL full_back_da: got %b want %b", dec, D_DA); end
      $display("test_full addr 0 done");
   endtask

   task automatic test_reset_mid();
      bus.pkt_valid = 1'b1;
      bus.data_in   = 8'h05;
      tick();
      tick();
      #1;
      n_cmp++; if (dec !== D_LD) begin n_err++; $display("FAIL rmid_ld: got %b want %b", dec, D_LD); end
      resetn = 1'b0;
      tick();
      #1;
      n_cmp++; if (dec !== D_DA) begin n_err++; $display("FAIL rmid_da: got %b want %b", dec, D_DA); end
      n_cmp++; if (bus.write_enb !== 3'b000) begin n_err++; $display("FAIL rmid_we: got %b want 000", bus.write_enb); end
      n_cmp++; if (bus.soft_reset !== 3'b000) begin n_err++; $display("FAIL rmid_srst: got %b want 000", bus.soft_reset); end
      resetn        = 1'b1;
      bus.pkt_valid = 1'b0;
      tick();
      #1;
      n_cmp++; if (bus.write_enb !== 3'b000) begin n_err++; $display("FAIL rmid_we_after: got %b want 000", bus.write_enb); end
      $display("test_reset_mid done");
   endtask

   // Port 1 stall schedule: 31 stalled, 2 idle, 29 stalled, read, 30 stalled, idle.
   task automatic test_timeout();
      int streak = 0;
      int pulses = 0;
      logic stalled, exp_p;
      idle_inputs();
      tick();
      for (int c = 0; c < 96; c++) begin
         bus.fifo_empty = ((c >= 31 && c < 33) || c >= 93) ? 3'b111 : 3'b101;
         bus.read_enb   = (c == 62) ? 3'b010 : 3'b000;
         stalled = !bus.fifo_empty[1] && !bus.read_enb[1];
         streak  = stalled ? streak + 1 : 0;
         exp_p   = TO_EN && stalled && (streak % TIMEOUT == 0);
         tick();
         n_cmp++; if (bus.soft_reset !== {1'b0, exp_p, 1'b0}) begin n_err++; $display("FAIL to_srst c%0d: got %b want %b", c, bus.soft_reset, {1'b0, exp_p, 1'b0}); end
         if (bus.soft_reset[1]) pulses++;
      end
      n_cmp++; if (pulses != (TO_EN ? 2 : 0)) begin n_err++; $display("FAIL to_pulses: got %0d want %0d", pulses, TO_EN ? 2 : 0); end
      idle_inputs();
      $display("test_timeout port 1 pulses %0d", pulses);
   endtask

   task automatic test_timeout_random();
      int streak [3] = '{0, 0, 0};
      logic [2:0] exp_p;
      int pulses = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            bus.fifo_empty[i] = ($urandom_range(0, 99) < 3);
            bus.read_enb[i]   = ($urandom_range(0, 99) < 2);
            if (!bus.fifo_empty[i] && !bus.read_enb[i]) streak[i]++;
            else streak[i] = 0;
            exp_p[i] = TO_EN && (streak[i] > 0) && (streak[i] % TIMEOUT == 0);
         end
         #1;
         n_cmp++; if (bus.vld_out !== ~bus.fifo_empty) begin n_err++; $display("FAIL rnd_vld c%0d: got %b want %b", c, bus.vld_out, ~bus.fifo_empty); end
         tick();
         n_cmp++; if (bus.soft_reset !== exp_p) begin n_err++; $display("FAIL rnd_srst c%0d: got %b want %b", c, bus.soft_reset, exp_p); end
         pulses += $countones(exp_p);
      end
      idle_inputs();
      tick();
      $display("test_timeout_random expected pulses %0d", pulses);
   endtask

   task automatic test_random_packets();
      for (int p = 0; p < 16; p++) begin
         int addr = $urandom_range(0, 2);
         int n    = $urandom_range(1, 6);
         logic [2:0] exp_we = 3'b001 << addr;
         int writes = 0;
         int cyc = 0;
         int ld_seen = 0;
         bit done = 0;
         bus.pkt_valid = 1'b1;
         bus.data_in   = {n[5:0], addr[1:0]};
         tick();
         while (!done && cyc < 40) begin
            if (bus.ld_state) begin
               bus.pkt_valid = (ld_seen < n - 1);
               bus.data_in   = 8'($urandom);
               ld_seen++;
            end else if (!bus.lfd_state) begin
               bus.pkt_valid = 1'b0;
            end
            #1;
            if (bus.write_enb !== 3'b000) begin
               writes++;
               n_cmp++; if (bus.write_enb !== exp_we) begin n_err++; $display("FAIL rpkt%0d_we: got %b want %b", p, bus.write_enb, exp_we); end
            end
            if (bus.detect_add) done = 1;
            else begin
               cyc++;
               tick();
            end
         end
         n_cmp++; if (cyc != n + 3) begin n_err++; $display("FAIL rpkt%0d_cycles: got %0d want %0d", p, cyc, n + 3); end
         n_cmp++; if (writes != n + 2) begin n_err++; $display("FAIL rpkt%0d_writes: got %0d want %0d", p, writes, n + 2); end
         $display("packet %0d addr %0d payload %0d writes %0d cycles %0d", p, addr, n, writes, cyc);
      end
      bus.pkt_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_packet();
      test_bad_addr();
      test_wait_empty();
      test_full();
      test_reset_mid();
      test_timeout();
      test_timeout_random();
      test_random_packets();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
